// File: rtl/lsu.sv
// Load/store unit: passes ALU results through and runs one req/gnt/rvalid data-bus access at a time.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
   parameter int REG_BUS_WIDTH      = 32,
   parameter int REG_ADDR_BUS_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          mem_re_i,
   input  logic                          mem_we_i,
   input  logic [2:0]                    mem_funct3_i,
   input  logic [REG_BUS_WIDTH-1:0]      mem_addr_i,
   input  logic [REG_BUS_WIDTH-1:0]      mem_wdata_i,
   input  logic                          rd_we_i,
   input  logic [REG_BUS_WIDTH-1:0]      rd_data_i,
   input  logic [REG_ADDR_BUS_WIDTH-1:0] rd_addr_i,
   output logic                          rd_we_o,
   output logic [REG_BUS_WIDTH-1:0]      rd_data_o,
   output logic [REG_ADDR_BUS_WIDTH-1:0] rd_addr_o,
   output logic                          dbus_req_o,
   output logic                          dbus_we_o,
   output logic [REG_BUS_WIDTH-1:0]      dbus_addr_o,
   output logic [3:0]                    dbus_be_o,
   output logic [REG_BUS_WIDTH-1:0]      dbus_wdata_o,
   input  logic                          dbus_gnt_i,
   input  logic                          dbus_rvalid_i,
   input  logic [REG_BUS_WIDTH-1:0]      dbus_rdata_i,
   input  logic [5:0]                    stall_i,
   input  logic [3:0]                    flush_i,
   output logic                          stall_req_o,
   output logic                          misalign_o,
   output logic [2:0]                    dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_RESP  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t                   r_state;
   logic                     r_we;
   logic [REG_BUS_WIDTH-1:0] r_addr;
   logic [3:0]               r_be;
   logic [REG_BUS_WIDTH-1:0] r_wdata;
   logic [1:0]               r_lane;
   logic [1:0]               r_size;
   logic                     r_uns;
   logic [REG_BUS_WIDTH-1:0] r_buf;

   logic [1:0]               w_size;
   logic                     w_uns;
   logic [1:0]               w_lane;
   logic [3:0]               w_be;
   logic [REG_BUS_WIDTH-1:0] w_wdata;
   logic [REG_BUS_WIDTH-1:0] w_aligned;
   logic [REG_BUS_WIDTH-1:0] w_ext;
   logic [7:0]               w_byte;
   logic [15:0]              w_half;
   logic                     w_mop;
   logic                     w_idle;
   logic                     w_flush;
   logic                     w_misalign;
   logic                     w_issue;
   logic                     w_in_req;
   logic                     w_unused;

   // Size decode; unused funct3 codes fall back to a word access. Lane bits
   // a word or half cannot use are masked so the access always goes out aligned.
   always_comb begin
      w_size = SZ_W;
      w_uns  = 1'b0;
      case (mem_funct3_i)
         3'b000: w_size = SZ_B;
         3'b001: w_size = SZ_H;
         3'b100: begin w_size = SZ_B; w_uns = 1'b1; end
         3'b101: begin w_size = SZ_H; w_uns = 1'b1; end
         default: ;
      endcase
      w_lane = mem_addr_i[1:0];
      if (w_size == SZ_W) w_lane = 2'b00;
      else if (w_size == SZ_H) w_lane[0] = 1'b0;
      case (w_size)
         SZ_B: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{mem_wdata_i[7:0]}};
         end
         SZ_H: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_wdata_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = mem_wdata_i;
         end
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = ((w_size == SZ_H) && mem_addr_i[0]) ||
                       ((w_size == SZ_W) && (mem_addr_i[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_aligned = {mem_addr_i[REG_BUS_WIDTH-1:2], 2'b00};
   assign w_mop     = mem_re_i | mem_we_i;
   assign w_idle    = (r_state == S_IDLE);
   assign w_in_req  = (r_state == S_REQ);
   assign w_flush   = flush_i[3];
   // rst_n is active-high here: nothing issues while reset is held.
   assign w_issue   = ~rst_n & w_idle & w_mop & ~w_flush & ~w_misalign;

   always_comb begin
      w_byte = dbus_rdata_i[{r_lane, 3'b000} +: 8];
      w_half = r_lane[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
      case (r_size)
         SZ_B:    w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
         SZ_H:    w_ext = {{16{~r_uns & w_half[15]}}, w_half};
         default: w_ext = dbus_rdata_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_lane  <= '0;
         r_size  <= SZ_W;
         r_uns   <= 1'b0;
         r_buf   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_issue) begin
               r_we    <= mem_we_i;
               r_addr  <= w_aligned;
               r_be    <= w_be;
               r_wdata <= w_wdata;
               r_lane  <= w_lane;
               r_size  <= w_size;
               r_uns   <= w_uns;
               r_state <= dbus_gnt_i ? S_RESP : S_REQ;
            end
            // A grant coinciding with a flush still leaves a response in flight.
            S_REQ: if (dbus_gnt_i) r_state <= w_flush ? S_DRAIN : S_RESP;
                   else if (w_flush) r_state <= S_IDLE;
            S_RESP: if (w_flush) r_state <= dbus_rvalid_i ? S_IDLE : S_DRAIN;
                    else if (dbus_rvalid_i) begin
                       r_buf   <= w_ext;
                       r_state <= S_DONE;
                    end
            S_DONE: if (w_flush || !stall_i[4]) r_state <= S_IDLE;
            S_DRAIN: if (dbus_rvalid_i) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dbus_req_o   = w_issue | w_in_req;
   assign dbus_we_o    = w_in_req ? r_we    : (w_issue ? mem_we_i  : 1'b0);
   assign dbus_addr_o  = w_in_req ? r_addr  : (w_issue ? w_aligned : '0);
   assign dbus_be_o    = w_in_req ? r_be    : (w_issue ? w_be      : 4'b0000);
   assign dbus_wdata_o = w_in_req ? r_wdata : (w_issue ? w_wdata   : '0);

   assign stall_req_o = w_issue | w_in_req | (r_state == S_RESP) | (r_state == S_DRAIN);
   assign misalign_o  = ~rst_n & w_idle & w_mop & w_misalign;

   assign rd_we_o   = (w_idle & ~w_mop) ? rd_we_i :
                      (r_state == S_DONE) ? (rd_we_i & ~r_we & ~w_flush) : 1'b0;
   assign rd_data_o = (r_state == S_DONE) ? r_buf : rd_data_i;
   assign rd_addr_o = rd_addr_i;

   assign dbg_state_o = r_state;
   assign w_unused    = ^{stall_i[5], stall_i[3:0], flush_i[2:0]};

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses checked
// against a byte-level arithmetic model of addressing, lane replication and extension.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_re_i, mem_we_i;
   logic [2:0]  mem_funct3_i;
   logic [31:0] mem_addr_i, mem_wdata_i;
   logic        rd_we_i;
   logic [31:0] rd_data_i;
   logic [4:0]  rd_addr_i;
   logic        rd_we_o;
   logic [31:0] rd_data_o;
   logic [4:0]  rd_addr_o;
   logic        dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_gnt_i, dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;
   logic [5:0]  stall_i;
   logic [3:0]  flush_i;
   logic        stall_req_o, misalign_o;
   logic [2:0]  dbg_state_o;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lsu dut (
      .clk(clk), .rst_n(rst_n),
      .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_funct3_i(mem_funct3_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .rd_we_i(rd_we_i), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
      .rd_we_o(rd_we_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .stall_req_o(stall_req_o), .misalign_o(misalign_o), .dbg_state_o(dbg_state_o)
   );

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic logic [31:0] ref_addr(input logic [31:0] a);
      return a - (a % 4);
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      if (size_of(f3) == 1) return 4'(1 << off);
      if (size_of(f3) == 2) return (off >= 2) ? 4'b1100 : 4'b0011;
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (size_of(f3) == 1) return (d % 256) * 32'h0101_0101;
      if (size_of(f3) == 2) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      longint v;
      int     off;
      bit     sgn;
      off = int'(a % 4);
      sgn = (f3 == 3'd0) || (f3 == 3'd1);
      if (size_of(f3) == 1) begin
         v = longint'((rd >> (8 * off)) % 256);
         if (sgn && v >= 128) v = v - 256;
      end else if (size_of(f3) == 2) begin
         v = longint'((rd >> (16 * (off / 2))) % 65536);
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(rd);
      end
      return 32'(v);
   endfunction

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      mem_re_i = 1'b0; mem_we_i = 1'b0; mem_funct3_i = 3'd0;
      mem_addr_i = '0; mem_wdata_i = '0;
      rd_we_i = 1'b0; rd_data_i = '0; rd_addr_i = '0;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
      stall_i = '0; flush_i = '0;
   endtask

   // One full access: issue, gd cycles waiting for grant, rv cycles of response
   // latency, then DONE held for `hold` extra cycles by stall_i[4].
   task automatic do_access(input logic re, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rdata, input int gd, input int rv,
                            input int hold, input string tag);
      logic [31:0] e_addr, e_wd, e_ld;
      logic [3:0]  e_be;
      logic [4:0]  ra;
      logic        e_rdwe;
      int          stalls;
      e_addr = ref_addr(a); e_be = ref_be(f3, a);
      e_wd = ref_wdata(f3, d); e_ld = ref_load(f3, a, rdata);
      e_rdwe = re & ~we;
      ra = 5'($urandom_range(0, 31));
      stalls = 0;
      mem_re_i = re; mem_we_i = we; mem_funct3_i = f3; mem_addr_i = a; mem_wdata_i = d;
      rd_we_i = 1'b1; rd_addr_i = ra; rd_data_i = $urandom;
      flush_i = '0; stall_i = '0;
      dbus_gnt_i = (gd == 0); dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
      #2;
      n_total++;
      if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, rd_we_o, misalign_o}
          !== {1'b1, we, e_addr, e_be, e_wd, 1'b0, 1'b0})
         $display("FAIL %s issue: req=%b we=%b addr=%h be=%b wdata=%h rdwe=%b mis=%b expected req=1 we=%b addr=%h be=%b wdata=%h rdwe=0 mis=0",
                  tag, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, rd_we_o,
                  misalign_o, we, e_addr, e_be, e_wd);
      else n_pass++;
      if (stall_req_o) stalls++;
      tick();
      for (int k = 1; k <= gd; k++) begin
         dbus_gnt_i = (k == gd); dbus_rvalid_i = 1'($urandom_range(0, 1));
         #2;
         n_total++;
         if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, rd_we_o}
             !== {1'b1, we, e_addr, e_be, e_wd, 1'b0})
            $display("FAIL %s req_hold c%0d: req=%b addr=%h be=%b wdata=%h rdwe=%b expected req=1 addr=%h be=%b wdata=%h rdwe=0",
                     tag, k, dbus_req_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, rd_we_o,
                     e_addr, e_be, e_wd);
         else n_pass++;
         if (stall_req_o) stalls++;
         tick();
      end
      for (int k = 0; k <= rv; k++) begin
         dbus_gnt_i = 1'($urandom_range(0, 1));
         dbus_rvalid_i = (k == rv);
         dbus_rdata_i = (k == rv) ? rdata : $urandom;
         #2;
         n_total++;
         if ({dbus_req_o, rd_we_o} !== 2'b00)
            $display("FAIL %s resp c%0d: req=%b rdwe=%b expected 0 0", tag, k, dbus_req_o, rd_we_o);
         else n_pass++;
         if (stall_req_o) stalls++;
         tick();
      end
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
      for (int k = 0; k <= hold; k++) begin
         stall_i = (k < hold) ? 6'b010000 : 6'b000000;
         #2;
         n_total++;
         if (rd_we_o !== e_rdwe || (e_rdwe && rd_data_o !== e_ld) || rd_addr_o !== ra ||
             stall_req_o !== 1'b0 || dbus_req_o !== 1'b0)
            $display("FAIL %s done c%0d: rdwe=%b data=%h addr=%0d stall=%b req=%b expected rdwe=%b data=%h addr=%0d stall=0 req=0",
                     tag, k, rd_we_o, rd_data_o, rd_addr_o, stall_req_o, dbus_req_o,
                     e_rdwe, e_ld, ra);
         else n_pass++;
         tick();
      end
      n_total++;
      if (stalls != 2 + gd + rv)
         $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, 2 + gd + rv);
      else n_pass++;
      drive_idle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_idle();
      rst_n = 1'b1;
      mem_re_i = 1'b1; mem_funct3_i = 3'd2; mem_addr_i = 32'h104; dbus_gnt_i = 1'b1;
      tick(); tick();
      #2;
      n_total++;
      if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, stall_req_o,
           misalign_o, rd_we_o, rd_data_o, rd_addr_o} !== '0)
         $display("FAIL reset_outputs: req=%b addr=%h be=%b stall=%b mis=%b rdwe=%b expected all 0",
                  dbus_req_o, dbus_addr_o, dbus_be_o, stall_req_o, misalign_o, rd_we_o);
      else n_pass++;
      tick();
      rst_n = 1'b0;
      drive_idle();
      #2;
      n_total++;
      if ({dbus_req_o, stall_req_o, misalign_o, rd_we_o, rd_data_o} !== '0)
         $display("FAIL post_reset_idle: req=%b stall=%b mis=%b rdwe=%b data=%h expected 0",
                  dbus_req_o, stall_req_o, misalign_o, rd_we_o, rd_data_o);
      else n_pass++;
      tick();
   endtask

   task automatic test_passthrough();
      logic        we;
      logic [4:0]  ad;
      logic [31:0] dt;
      for (int i = 0; i < 5; i++) begin
         we = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         ad = (i == 0) ? 5'd5 : 5'($urandom_range(0, 31));
         dt = (i == 0) ? 32'h1234 : $urandom;
         rd_we_i = we; rd_addr_i = ad; rd_data_i = dt;
         dbus_gnt_i = 1'($urandom_range(0, 1)); dbus_rvalid_i = 1'($urandom_range(0, 1));
         #2;
         n_total++;
         if ({rd_we_o, rd_addr_o, rd_data_o, dbus_req_o, stall_req_o} !== {we, ad, dt, 2'b00})
            $display("FAIL passthrough %0d: we=%b addr=%0d data=%h req=%b stall=%b expected we=%b addr=%0d data=%h req=0 stall=0",
                     i, rd_we_o, rd_addr_o, rd_data_o, dbus_req_o, stall_req_o, we, ad, dt);
         else n_pass++;
         tick();
      end
      drive_idle();
   endtask

   task automatic test_directed_ops();
      do_access(1'b1, 1'b0, 3'd0, 32'h103, $urandom, 32'h80FF_FFFF, 0, 0, 0, "lb_0x103");
      do_access(1'b1, 1'b0, 3'd5, 32'h102, $urandom, 32'hABCD_0000, 3, 0, 0, "lhu_0x102");
      do_access(1'b0, 1'b1, 3'd0, 32'h201, 32'h55, $urandom, 0, 0, 0, "sb_0x201");
      do_access(1'b1, 1'b0, 3'd1, 32'h302, $urandom, 32'h8001_1234, 1, 2, 2, "lh_sext_hold");
      do_access(1'b1, 1'b0, 3'd2, 32'h400, $urandom, 32'hCAFE_F00D, 0, 1, 0, "lw");
   endtask

   task automatic test_reset_mid();
      mem_re_i = 1'b1; mem_funct3_i = 3'd2; mem_addr_i = 32'h500; dbus_gnt_i = 1'b1;
      tick();
      dbus_gnt_i = 1'b0; rst_n = 1'b1;
      tick();
      rst_n = 1'b0; mem_re_i = 1'b0; rd_we_i = 1'b1; rd_data_i = $urandom;
      #2;
      n_total++;
      if ({dbus_req_o, stall_req_o, rd_we_o, rd_data_o} !== {2'b00, 1'b1, rd_data_i})
         $display("FAIL reset_mid: req=%b stall=%b rdwe=%b data=%h expected 0 0 1 %h",
                  dbus_req_o, stall_req_o, rd_we_o, rd_data_o, rd_data_i);
      else n_pass++;
      tick();
      drive_idle();
      do_access(1'b1, 1'b0, 3'd4, 32'h502, $urandom, 32'h0099_0000, 0, 0, 0, "lbu_after_rst");
   endtask

   task automatic test_flush_req();
      mem_re_i = 1'b1; mem_funct3_i = 3'd0; mem_addr_i = 32'h600;
      tick();
      flush_i = 4'b1000;
      tick();
      drive_idle();
      rd_we_i = 1'b1; rd_data_i = $urandom;
      #2;
      n_total++;
      if ({dbus_req_o, stall_req_o, rd_we_o, rd_data_o} !== {2'b00, 1'b1, rd_data_i})
         $display("FAIL flush_req: req=%b stall=%b rdwe=%b data=%h expected 0 0 1 %h",
                  dbus_req_o, stall_req_o, rd_we_o, rd_data_o, rd_data_i);
      else n_pass++;
      tick();
      drive_idle();
   endtask

   task automatic test_flush_resp();
      mem_re_i = 1'b1; mem_funct3_i = 3'd2; mem_addr_i = 32'h300; rd_we_i = 1'b1;
      dbus_gnt_i = 1'b1;
      tick();
      dbus_gnt_i = 1'b0; flush_i = 4'b1000;
      #2;
      n_total++;
      if ({stall_req_o, rd_we_o} !== 2'b10)
         $display("FAIL flush_resp: stall=%b rdwe=%b expected 1 0", stall_req_o, rd_we_o);
      else n_pass++;
      tick();
      flush_i = '0; mem_addr_i = 32'h404;
      for (int k = 0; k < 2; k++) begin
         dbus_rvalid_i = (k == 1); dbus_rdata_i = $urandom;
         #2;
         n_total++;
         if ({dbus_req_o, stall_req_o, rd_we_o} !== 3'b010)
            $display("FAIL drain c%0d: req=%b stall=%b rdwe=%b expected 0 1 0",
                     k, dbus_req_o, stall_req_o, rd_we_o);
         else n_pass++;
         tick();
      end
      do_access(1'b1, 1'b0, 3'd2, 32'h404, $urandom, 32'h1357_9BDF, 0, 0, 0, "lw_after_drain");
   endtask

   task automatic test_flush_rvalid_same();
      mem_re_i = 1'b1; mem_funct3_i = 3'd2; mem_addr_i = 32'h700; rd_we_i = 1'b1;
      dbus_gnt_i = 1'b1;
      tick();
      dbus_gnt_i = 1'b0; flush_i = 4'b1000; dbus_rvalid_i = 1'b1; dbus_rdata_i = $urandom;
      #2;
      n_total++;
      if (rd_we_o !== 1'b0)
         $display("FAIL flush_rvalid: rdwe=%b expected 0", rd_we_o);
      else n_pass++;
      tick();
      drive_idle();
      rd_we_i = 1'b1; rd_data_i = $urandom;
      #2;
      n_total++;
      if ({stall_req_o, dbus_req_o, rd_we_o, rd_data_o} !== {2'b00, 1'b1, rd_data_i})
         $display("FAIL flush_rvalid_idle: stall=%b req=%b rdwe=%b data=%h expected 0 0 1 %h",
                  stall_req_o, dbus_req_o, rd_we_o, rd_data_o, rd_data_i);
      else n_pass++;
      tick();
      drive_idle();
   endtask

   task automatic test_flush_done();
      mem_re_i = 1'b1; mem_funct3_i = 3'd2; mem_addr_i = 32'h800; rd_we_i = 1'b1;
      dbus_gnt_i = 1'b1;
      tick();
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = $urandom;
      tick();
      dbus_rvalid_i = 1'b0; stall_i = 6'b010000; flush_i = 4'b1000;
      #2;
      n_total++;
      if ({rd_we_o, stall_req_o} !== 2'b00)
         $display("FAIL flush_done: rdwe=%b stall=%b expected 0 0", rd_we_o, stall_req_o);
      else n_pass++;
      tick();
      drive_idle();
      rd_we_i = 1'b1; rd_data_i = $urandom;
      #2;
      n_total++;
      if ({rd_we_o, rd_data_o} !== {1'b1, rd_data_i})
         $display("FAIL flush_done_idle: rdwe=%b data=%h expected 1 %h", rd_we_o, rd_data_o, rd_data_i);
      else n_pass++;
      tick();
      drive_idle();
   endtask

   task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
      logic [31:0] addrs [2];
      logic [2:0]  f3s [2];
      addrs[0] = 32'h102; f3s[0] = 3'd2;
      addrs[1] = 32'h101; f3s[1] = 3'd1;
      for (int i = 0; i < 2; i++) begin
         mem_re_i = 1'b1; mem_funct3_i = f3s[i]; mem_addr_i = addrs[i]; rd_we_i = 1'b1;
         for (int k = 0; k < 2; k++) begin
            #2;
            n_total++;
            if ({misalign_o, dbus_req_o, stall_req_o, rd_we_o} !== 4'b1000)
               $display("FAIL misalign %0d c%0d: mis=%b req=%b stall=%b rdwe=%b expected 1 0 0 0",
                        i, k, misalign_o, dbus_req_o, stall_req_o, rd_we_o);
            else n_pass++;
            tick();
         end
      end
      drive_idle();
      #2;
      n_total++;
      if (misalign_o !== 1'b0)
         $display("FAIL misalign_clear: mis=%b expected 0", misalign_o);
      else n_pass++;
      tick();
      do_access(1'b1, 1'b0, 3'd1, 32'h102, $urandom, 32'hFEDC_0000, 0, 0, 0, "lh_aligned");
`else
      do_access(1'b1, 1'b0, 3'd2, 32'h102, $urandom, 32'h1122_3344, 1, 0, 0, "lw_0x102_masked");
      do_access(1'b1, 1'b0, 3'd1, 32'h103, $urandom, 32'h9ABC_5678, 0, 0, 0, "lh_0x103_masked");
`endif
   endtask

   task automatic test_random();
      logic [2:0]  f3_tab [8];
      logic [2:0]  f3;
      logic [31:0] a;
      logic        st;
      f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4;
      f3_tab[4] = 3'd5; f3_tab[5] = 3'd3; f3_tab[6] = 3'd6; f3_tab[7] = 3'd7;
      for (int i = 0; i < 40; i++) begin
         f3 = f3_tab[$urandom_range(0, 7)];
         st = 1'($urandom_range(0, 1));
         a = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
         a = a - (a % size_of(f3));
`endif
         do_access(~st, st, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2), "rand");
      end
   endtask

   initial begin
      drive_idle();
      rst_n = 1'b1;
      test_reset();
      test_passthrough();
      test_directed_ops();
      test_reset_mid();
      test_flush_req();
      test_flush_resp();
      test_flush_rvalid_same();
      test_flush_done();
      test_misalign();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the memory stage. Sits between the ex/ls pipeline register and the ls/wb register: it passes ALU results through, and it runs a request/grant/response data-bus transaction for loads and stores. While an access is in flight it raises a stall request to ctrl. Load data is sign- or zero-extended and presented to ls/wb as the rd write-back value.

## Interface
- `REG_BUS_WIDTH`, 32: data width (codebase define).
- `REG_ADDR_BUS_WIDTH`, 5: rd address width (codebase define).
- `clk` input 1: single clock.
- `rst_n` input 1: reset, synchronous, active-high (1 = reset).
- `mem_re_i` input 1: instruction is a load.
- `mem_we_i` input 1: instruction is a store.
- `mem_funct3_i` input 3: size code, decoded as follows.
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Any other value is treated as W.
- `mem_addr_i` input 32: effective byte address.
- `mem_wdata_i` input 32: store data (rs2).
- `rd_we_i`, `rd_data_i`, `rd_addr_i` input 1/32/5: write-back fields from ex/ls.
- `rd_we_o`, `rd_data_o`, `rd_addr_o` output 1/32/5: to ls/wb.
- `dbus_req_o` output 1: bus request.
- `dbus_we_o` output 1: 1 = write.
- `dbus_addr_o` output 32: word-aligned address, {addr[31:2], 2'b00}.
- `dbus_be_o` output 4: byte enables.
- `dbus_wdata_o` output 32: store data replicated across lanes.
  - B = {4{d[7:0]}}.
  - H = {2{d[15:0]}}.
- `dbus_gnt_i` input 1: request accepted this cycle.
- `dbus_rvalid_i`, `dbus_rdata_i` input 1/32: response; for stores this is the write acknowledge.
- `stall_i` input 6: ctrl stall vector; bit 4 holds this stage.
- `flush_i` input 4: ctrl flush vector; bit 3 kills the instruction in this stage.
- `stall_req_o` output 1: request ctrl to stall this stage and all stages before it.
- `misalign_o` output 1: misaligned-access flag (see Configuration).

## Operation
- The block is a memory op when `mem_re_i | mem_we_i` (call this `mop`).
- Non-memory ops:
  - `rd_*_o` = `rd_*_i`, combinationally.
  - No bus activity; `stall_req_o`=0.
- States:
  - IDLE
  - REQ: request asserted, waiting for grant.
  - RESP: granted, waiting for `rvalid`.
  - DONE: response captured, waiting for ls/wb to load.
  - DRAIN: flushed while granted; absorb the outstanding response.
- Transitions:
  - IDLE:
    - Condition to issue: `mop` & !`flush_i[3]` & !misaligned-trap.
    - On issue, drive `dbus_req_o`=1.
    - `gnt` → RESP; otherwise → REQ.
  - REQ:
    - Hold req, addr, be, we and wdata stable until `gnt` → RESP.
    - `flush_i[3]` before grant → drop req, IDLE.
  - RESP:
    - `rvalid` → capture the extended load data into the result buffer, → DONE.
    - `flush_i[3]` → DRAIN.
  - DONE:
    - `rd_*_o` come from the buffer.
    - `!stall_i[4]` → IDLE.
    - `flush_i[3]` → IDLE, with `rd_we_o`=0.
  - DRAIN:
    - `stall_req_o`=1, `rd_we_o`=0.
    - `rvalid` → IDLE, data discarded.
- `stall_req_o` = 1 in:
  - IDLE when issuing,
  - REQ, RESP and DRAIN.
  - It is 0 in DONE.
- `rd_we_o` is 0 in IDLE, REQ and RESP for a memory op.
- In DONE:
  - `rd_we_o` = `rd_we_i` for loads, 0 for stores.
  - `rd_data_o` = buffer.
- Byte enables, with a = `addr[1:0]`:
  - B: `1<<a`.
  - H: `a[1] ? 1100 : 0011`.
  - W: 1111.
- Load extract:
  - Select the lane by a.
  - B/H sign-extend; BU/HU zero-extend.
- At most one outstanding transaction, ever.
- A `gnt` or `rvalid` arriving in an unexpected state is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, buffer 0.
- Reset mid-transaction: state returns to IDLE and `dbus_req_o` drops the next cycle. The bus is assumed reset together with this block.
- Best-case memory op, with `gnt` in cycle 0 and `rvalid` in cycle 1:
  - Cycle 0: IDLE, issue.
  - Cycle 1: RESP.
  - Cycle 2: DONE, output valid.
  - `stall_req_o` is high in cycles 0–1; ls/wb loads at the end of cycle 2.
- Each cycle of `gnt` or `rvalid` latency adds one cycle.
- `rvalid` may not arrive in the same cycle as `gnt`; if it does, it is ignored.
- Flush and `rvalid` in the same RESP cycle: the flush wins and the state goes to IDLE. Data is discarded and `stall_req_o` falls.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned access in IDLE (H with `a[0]`=1, or W with a≠00) does not issue.
  - `misalign_o`=1 while the op is present, with `stall_req_o`=0 and `rd_we_o`=0.
  - ctrl flushes on `misalign_o`.
- Undefined:
  - `misalign_o` is tied 0.
  - Low address bits are masked: W ignores `a`, H ignores `a[0]`.
  - The access proceeds aligned.

## Test plan
- Non-mem op, `rd_we_i`=1, `rd_addr_i`=5, `rd_data_i`=0x1234 → same values on `rd_*_o` in the same cycle; `dbus_req_o`=0, `stall_req_o`=0.
- LB at addr 0x103, `gnt` immediate, `rvalid` next cycle with rdata=0x80FF_FFFF:
  - `dbus_addr_o`=0x100, be=1000.
  - DONE `rd_data_o`=0xFFFF_FF80.
  - `stall_req_o` high exactly 2 cycles.
- LHU at addr 0x102, `gnt` delayed 3 cycles, rdata=0xABCD_0000:
  - req, addr and be held stable through REQ.
  - Result 0x0000_ABCD.
- SB at 0x201, data 0x55 → be=0010, wdata=0x5555_5555, `rd_we_o`=0 in DONE.
- `flush_i[3]` in RESP, `rvalid` 2 cycles later → DRAIN, then IDLE; `rd_we_o` never 1; the next load issues only after `rvalid`.
- With `LSU_MISALIGN_TRAP_EN`, LW at 0x102 → `misalign_o`=1, no req; without the macro → req at 0x100 with be=1111.
